// File: rtl/instr_mem_responder_pkg.sv
// Definitions shared by the instruction-side memory model.
package riscv_defines;

  localparam int unsigned WORD_WIDTH = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

endpackage

// File: rtl/instr_mem_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to generate grant stalls.
module instr_mem_lfsr (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= seed;
    end else if (en) begin
      state <= {state[0] ^ state[2] ^ state[3] ^ state[5], state[15:1]};
    end
  end

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: req/gnt/rvalid slave over a word array with a
// fixed-latency in-order response pipeline and optional pseudo-random stalls.
module instr_mem_responder #(
  parameter int unsigned WORD_WIDTH     = riscv_defines::WORD_WIDTH,
  parameter int unsigned MEM_WORDS_LOG2 = 10,
  parameter int unsigned LATENCY        = 1,
  parameter bit          STALL_EN       = 1'b0,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_req_i,
  input  logic [WORD_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [WORD_WIDTH-1:0] instr_rdata_o,
  output logic                  instr_err_o,
  input  logic                  load_we_i,
  input  logic [WORD_WIDTH-1:0] load_addr_i,
  input  logic [WORD_WIDTH-1:0] load_wdata_i
);
  import riscv_defines::*;

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("instr_mem_responder: LATENCY must be in 1..4");
  end

  localparam int unsigned DEPTH = 2 ** MEM_WORDS_LOG2;

  logic [WORD_WIDTH-1:0]     mem [DEPTH];
  logic [15:0]               lfsr;
  logic                      stall;
  logic [MEM_WORDS_LOG2-1:0] rd_idx;
  logic [MEM_WORDS_LOG2-1:0] ld_idx;
  logic                      rd_err;
  logic                      ld_ok;
  logic [WORD_WIDTH-1:0]     rd_word;
  logic                      lint_unused;

  logic [LATENCY-1:0]        vld_q;
  logic [LATENCY-1:0]        err_q;
  logic [WORD_WIDTH-1:0]     dat_q [LATENCY];

  instr_mem_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (STALL_EN),
    .seed  (LFSR_SEED),
    .state (lfsr)
  );

  assign stall       = STALL_EN & lfsr[0];
  assign instr_gnt_o = instr_req_i & ~load_we_i & ~stall & ~rst;
  assign lint_unused = ^{lfsr[15:1], load_addr_i[1:0]};

  always_comb begin
    rd_idx  = instr_addr_i[MEM_WORDS_LOG2+1:2];
    ld_idx  = load_addr_i[MEM_WORDS_LOG2+1:2];
    rd_err  = (instr_addr_i[1:0] != 2'b00) ||
              ((instr_addr_i >> (MEM_WORDS_LOG2 + 2)) != '0);
    ld_ok   = ((load_addr_i >> (MEM_WORDS_LOG2 + 2)) == '0);
    rd_word = rd_err ? WORD_WIDTH'(NOP_INSTR) : mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (load_we_i && ld_ok) begin
      mem[ld_idx] <= load_wdata_i;
    end
  end

  // Valid bits shift every cycle; data/err only move with a valid token so the
  // last stage (the outputs) holds its value between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      err_q <= '0;
      for (int unsigned k = 0; k < LATENCY; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= instr_gnt_o;
      if (instr_gnt_o) begin
        dat_q[0] <= rd_word;
        err_q[0] <= rd_err;
      end
      for (int unsigned k = 1; k < LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          dat_q[k] <= dat_q[k-1];
          err_q[k] <= err_q[k-1];
        end
      end
    end
  end

  assign instr_rvalid_o = vld_q[LATENCY-1];
  assign instr_rdata_o  = dat_q[LATENCY-1];
  assign instr_err_o    = err_q[LATENCY-1];

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench: four responders (latency 1/2/3, and 2 with stalls) driven
// by directed steps; expected responses are queued at grant and popped at rvalid.
module tb_instr_mem_responder;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef struct {
    int          id;
    logic [31:0] d;
    logic        e;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_c, st_req;
  logic [31:0] addr_c, st_addr;
  logic        ld_we;
  logic [31:0] ld_addr, ld_wdata;

  logic        req    [4];
  logic [31:0] addr   [4];
  logic        gnt    [4];
  logic        rvalid [4];
  logic [31:0] rdata  [4];
  logic        err    [4];

  logic [31:0] mem_m [1024];
  logic [15:0] lfsr_m;
  exp_t        sb [$];
  int          cyc;
  int          tests;
  int          fails;
  logic        st_gnt_seen;
  int          stall_seen;
  int          st_grants;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    assign req[g]  = (g == 3) ? st_req  : req_c;
    assign addr[g] = (g == 3) ? st_addr : addr_c;
    instr_mem_responder #(
      .WORD_WIDTH     (32),
      .MEM_WORDS_LOG2 (10),
      .LATENCY        ((g == 0) ? 1 : (g == 2) ? 3 : 2),
      .STALL_EN       (g == 3),
      .LFSR_SEED      (SEED)
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .instr_req_i    (req[g]),
      .instr_addr_i   (addr[g]),
      .instr_gnt_o    (gnt[g]),
      .instr_rvalid_o (rvalid[g]),
      .instr_rdata_o  (rdata[g]),
      .instr_err_o    (err[g]),
      .load_we_i      (ld_we),
      .load_addr_i    (ld_addr),
      .load_wdata_i   (ld_wdata)
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : (g == 2) ? 3 : 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference stall LFSR: taps 16,14,13,11, shifting toward bit 0.
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= SEED;
    else     lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
  end

  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      logic eg;
      logic ae;
      int   idx;
      eg = req[g] & ~ld_we & ~((g == 3) & lfsr_m[0]) & ~rst;
      chk($sformatf("gnt%0d", g), {31'b0, gnt[g]}, {31'b0, eg});
      if (g == 3 && !rst && req[3]) begin
        if (gnt[3]) st_grants++;
        else        stall_seen++;
      end
      if (g == 3) st_gnt_seen = gnt[3];
      if (eg && gnt[g]) begin
        ae = (addr[g][1:0] != 2'b00) || (addr[g][31:12] != 20'd0);
        sb.push_back('{id: g, d: ae ? NOP : mem_m[addr[g][11:2]], e: ae, due: cyc + lat_of(g)});
      end
      if (rst) begin
        chk($sformatf("rst_rvalid%0d", g), {31'b0, rvalid[g]}, 32'd0);
        chk($sformatf("rst_rdata%0d", g), rdata[g], 32'd0);
        chk($sformatf("rst_err%0d", g), {31'b0, err[g]}, 32'd0);
      end else begin
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
          if (idx < 0 && sb[i].id == g) idx = i;
        end
        if (rvalid[g]) begin
          if (idx < 0) begin
            chk($sformatf("spurious_rvalid%0d", g), 32'd1, 32'd0);
          end else begin
            chk($sformatf("rdata%0d", g), rdata[g], sb[idx].d);
            chk($sformatf("err%0d", g), {31'b0, err[g]}, {31'b0, sb[idx].e});
            chk($sformatf("latency%0d", g), cyc, sb[idx].due);
            sb.delete(idx);
          end
        end else if (idx >= 0 && sb[idx].due <= cyc) begin
          chk($sformatf("missing_rvalid%0d", g), 32'd0, 32'd1);
          sb.delete(idx);
        end
      end
    end
    if (rst) sb.delete();
    if (ld_we && ld_addr[31:12] == 20'd0) mem_m[ld_addr[11:2]] = ld_wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc = 0; tests = 0; fails = 0;
    stall_seen = 0; st_grants = 0; st_gnt_seen = 1'b0;
    rst = 1'b0; req_c = 1'b0; st_req = 1'b0; addr_c = '0; st_addr = '0;
    ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
    #1 rst = 1'b1;
    req_c = 1'b1; st_req = 1'b1;
    repeat (3) step();
    rst = 1'b0; req_c = 1'b0; st_req = 1'b0;
    step();

    // Preload words 0x000..0x03C
    for (int i = 0; i < 16; i++) begin
      ld_we    = 1'b1;
      ld_addr  = 32'(i * 4);
      ld_wdata = (i == 0) ? 32'h0050_0093 : (i == 1) ? 32'h00A0_0113 : 32'h1000_0000 + 32'(i * 32'h0101);
      step();
    end
    ld_we = 1'b0;
    step();

    // Back-to-back fetches of 0x000, 0x004
    req_c = 1'b1; addr_c = 32'h0; step();
    addr_c = 32'h4; step();
    req_c = 1'b0; repeat (5) step();

    // Four-beat burst from 0x010
    req_c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr_c = 32'h10 + 32'(i * 4);
      step();
    end
    req_c = 1'b0; repeat (5) step();

    // Misaligned and out-of-range fetches, then confirm word 0 untouched
    req_c = 1'b1; addr_c = 32'h2; step();
    addr_c = 32'h1000; step();
    addr_c = 32'h0; step();
    req_c = 1'b0; repeat (5) step();

    // Out-of-range loader write must not alias onto word 0
    ld_we = 1'b1; ld_addr = 32'h1000; ld_wdata = 32'hBAD0_BAD0; step();
    ld_we = 1'b0; req_c = 1'b1; addr_c = 32'h0; step();
    req_c = 1'b0; repeat (5) step();

    // Loader write blocks a same-cycle request to the same word
    req_c = 1'b1; addr_c = 32'h8;
    ld_we = 1'b1; ld_addr = 32'h8; ld_wdata = 32'hCAFE_F00D; step();
    ld_we = 1'b0; step();
    req_c = 1'b0; repeat (5) step();

    // Write after grant returns old data; refetch sees new data
    req_c = 1'b1; addr_c = 32'hC; step();
    req_c = 1'b0; ld_we = 1'b1; ld_addr = 32'hC; ld_wdata = 32'hDEAD_BEEF; step();
    ld_we = 1'b0; req_c = 1'b1; addr_c = 32'hC; step();
    req_c = 1'b0; repeat (5) step();

    // Stall stress with a reset pulse mid-burst
    st_req = 1'b1; st_addr = 32'h0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (st_gnt_seen) st_addr = (st_addr + 32'h4) & 32'h3C;
      if (i == 120) rst = 1'b1;
      if (i == 122) rst = 1'b0;
    end
    st_req = 1'b0;
    repeat (6) step();

    chk("stalls_observed", {31'b0, stall_seen > 0}, 32'd1);
    chk("stall_grants", {31'b0, st_grants > 0}, 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
